// File: rtl/sad_tree_pipe_if.sv
// Row-beat input bundle and block/best SAD result bundle for sad_tree_pipe.
// The master side feeds pixel rows and search control; the slave side is the SAD engine.
interface sad_tree_pipe_if #(
    parameter int LANES    = 16,
    parameter int PIX_W    = 8,
    parameter int MAX_ROWS = 16,
    parameter int IDX_W    = 8
);
    localparam int ACC_W = PIX_W + $clog2(LANES) + $clog2(MAX_ROWS);

    logic                   in_valid;
    logic                   in_first;
    logic                   in_last;
    logic [IDX_W-1:0]       cand_idx;
    logic [LANES*PIX_W-1:0] a_pix;
    logic [LANES*PIX_W-1:0] b_pix;
    logic                   search_clear;
    logic                   sad_valid;
    logic [ACC_W-1:0]       sad_out;
    logic [IDX_W-1:0]       sad_idx;
    logic                   best_valid;
    logic [ACC_W-1:0]       best_sad;
    logic [IDX_W-1:0]       best_idx;

    modport master (
        output in_valid, in_first, in_last, cand_idx, a_pix, b_pix, search_clear,
        input  sad_valid, sad_out, sad_idx, best_valid, best_sad, best_idx
    );

    modport slave (
        input  in_valid, in_first, in_last, cand_idx, a_pix, b_pix, search_clear,
        output sad_valid, sad_out, sad_idx, best_valid, best_sad, best_idx
    );
endinterface

// File: rtl/sad_tree_pipe.sv
// Pipelined sum-of-absolute-differences engine: per-lane |a-b|, registered adder tree,
// saturating per-block accumulator and a running-minimum tracker over a search.
module sad_tree_pipe #(
    parameter int LANES    = 16,
    parameter int PIX_W    = 8,
    parameter int MAX_ROWS = 16,
    parameter int IDX_W    = 8
) (
    input  logic           clk,
    input  logic           rst,
    sad_tree_pipe_if.slave bus
);
    localparam int LOG2  = $clog2(LANES);
    localparam int L     = LOG2 + 1;
    localparam int RS_W  = PIX_W + LOG2;
    localparam int ACC_W = RS_W + $clog2(MAX_ROWS);

    function automatic logic [PIX_W-1:0] absdiff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Level 0 holds the lane differences; each further level halves the node count.
    genvar gi;
    generate
        for (gi = 0; gi <= LOG2; gi++) begin : lvl
            localparam int N = LANES >> gi;
            localparam int W = PIX_W + gi;
            logic [W-1:0] node [N];

            if (gi == 0) begin : g_abs
                always_ff @(posedge clk) begin
                    for (int j = 0; j < N; j++) begin
                        node[j] <= absdiff(bus.a_pix[j*PIX_W +: PIX_W], bus.b_pix[j*PIX_W +: PIX_W]);
                    end
                end
            end else begin : g_add
                always_ff @(posedge clk) begin
                    for (int j = 0; j < N; j++) begin
                        node[j] <= W'(lvl[gi-1].node[2*j]) + W'(lvl[gi-1].node[2*j+1]);
                    end
                end
            end
        end
    endgenerate

    logic [RS_W-1:0] row_sum;
    assign row_sum = lvl[LOG2].node[0];

    // Sideband markers ride along with the tree so they emerge alongside row_sum.
    logic [L-1:0]     vld_reg;
    logic [L-1:0]     first_reg;
    logic [L-1:0]     last_reg;
    logic [IDX_W-1:0] idx_reg [L];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_reg   <= '0;
            first_reg <= '0;
            last_reg  <= '0;
            for (int k = 0; k < L; k++) idx_reg[k] <= '0;
        end else begin
            vld_reg   <= {vld_reg[L-2:0], bus.in_valid};
            first_reg <= {first_reg[L-2:0], bus.in_valid & bus.in_first};
            last_reg  <= {last_reg[L-2:0], bus.in_valid & bus.in_last};
            idx_reg[0] <= bus.cand_idx;
            for (int k = 1; k < L; k++) idx_reg[k] <= idx_reg[k-1];
        end
    end

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_next;

    always_comb begin
        acc_base = first_reg[L-1] ? '0 : acc_reg;
        acc_sum  = {1'b0, acc_base} + (ACC_W+1)'(row_sum);
        acc_next = acc_sum[ACC_W] ? '1 : acc_sum[ACC_W-1:0];
    end

    logic             sad_valid_reg;
    logic [ACC_W-1:0] sad_out_reg;
    logic [IDX_W-1:0] sad_idx_reg;

    // The accumulator is cleared on every block end so an unmarked next beat starts from 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg       <= '0;
            sad_valid_reg <= 1'b0;
            sad_out_reg   <= '0;
            sad_idx_reg   <= '0;
        end else begin
            sad_valid_reg <= 1'b0;
            if (vld_reg[L-1]) begin
                if (last_reg[L-1]) begin
                    sad_valid_reg <= 1'b1;
                    sad_out_reg   <= acc_next;
                    sad_idx_reg   <= idx_reg[L-1];
                    acc_reg       <= '0;
                end else begin
                    acc_reg <= acc_next;
                end
            end
        end
    end

    logic             best_valid_reg, best_valid_next;
    logic [ACC_W-1:0] best_sad_reg, best_sad_next;
    logic [IDX_W-1:0] best_idx_reg, best_idx_next;

    // A clear coinciding with a new SAD makes that SAD the first entry of the new search.
    always_comb begin
        best_valid_next = best_valid_reg;
        best_sad_next   = best_sad_reg;
        best_idx_next   = best_idx_reg;
        if (sad_valid_reg && (bus.search_clear || !best_valid_reg || (sad_out_reg < best_sad_reg))) begin
            best_valid_next = 1'b1;
            best_sad_next   = sad_out_reg;
            best_idx_next   = sad_idx_reg;
        end else if (bus.search_clear) begin
            best_valid_next = 1'b0;
            best_sad_next   = '1;
            best_idx_next   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_valid_reg <= 1'b0;
            best_sad_reg   <= '1;
            best_idx_reg   <= '0;
        end else begin
            best_valid_reg <= best_valid_next;
            best_sad_reg   <= best_sad_next;
            best_idx_reg   <= best_idx_next;
        end
    end

    assign bus.sad_valid  = sad_valid_reg;
    assign bus.sad_out    = sad_out_reg;
    assign bus.sad_idx    = sad_idx_reg;
    assign bus.best_valid = best_valid_reg;
    assign bus.best_sad   = best_sad_reg;
    assign bus.best_idx   = best_idx_reg;
endmodule

// File: tb/tb_sad_tree_pipe.sv
// Bench for sad_tree_pipe: directed block cases plus random beats, checked every cycle
// against a block-level arithmetic model of SAD, pulse timing and the minimum tracker.
module tb_sad_tree_pipe;
    localparam int LANES    = 16;
    localparam int PIX_W    = 8;
    localparam int MAX_ROWS = 16;
    localparam int IDX_W    = 8;
    localparam int ACC_MAX  = 65535;
    localparam int PULSE    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sad_tree_pipe_if #(.LANES(LANES), .PIX_W(PIX_W), .MAX_ROWS(MAX_ROWS), .IDX_W(IDX_W)) bus ();

    sad_tree_pipe #(.LANES(LANES), .PIX_W(PIX_W), .MAX_ROWS(MAX_ROWS), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sad;
        int idx;
        int due;
    } exp_t;
    exp_t q[$];

    int model_acc = 0;
    int hold_sad  = 0;
    int hold_idx  = 0;
    int mbs       = ACC_MAX;
    int mbi       = 0;
    bit mbv       = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [LANES*PIX_W-1:0] fill(input int v);
        logic [LANES*PIX_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*PIX_W +: PIX_W] = PIX_W'(v);
        return r;
    endfunction

    // One input beat per call; the model derives the block SAD straight from the pixels.
    task automatic drive(input bit v, input bit f, input bit l, input int idx,
                         input logic [LANES*PIX_W-1:0] a, input logic [LANES*PIX_W-1:0] b,
                         input bit clr);
        int row, base, s, ai, bi;
        @(posedge clk);
        #1;
        bus.in_valid     = v;
        bus.in_first     = f;
        bus.in_last      = l;
        bus.cand_idx     = IDX_W'(idx);
        bus.a_pix        = a;
        bus.b_pix        = b;
        bus.search_clear = clr;
        if (v) begin
            row = 0;
            for (int i = 0; i < LANES; i++) begin
                ai = int'(a[i*PIX_W +: PIX_W]);
                bi = int'(b[i*PIX_W +: PIX_W]);
                row += (ai > bi) ? ai - bi : bi - ai;
            end
            base = f ? 0 : model_acc;
            s = base + row;
            if (s > ACC_MAX) s = ACC_MAX;
            if (l) begin
                q.push_back('{sad: s, idx: idx & 255, due: cyc + PULSE});
                model_acc = 0;
            end else begin
                model_acc = s;
            end
        end
    endtask

    task automatic idle(input int n, input bit clr = 1'b0);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 0, '0, '0, clr);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.search_clear = 1'b0;
        model_acc = 0;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_sad(input string name, input int es, input int ei);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            idle(1);
            @(negedge clk);
            if (bus.sad_valid) begin
                seen = 1'b1;
                chk({name, "_sad"}, 32'(bus.sad_out), es);
                chk({name, "_idx"}, 32'(bus.sad_idx), ei);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no sad_valid expected pulse within 20 cycles", name);
        end
    endtask

    task automatic check_best(input string name, input int bs, input int bi);
        idle(1);
        @(negedge clk);
        chk({name, "_best_valid"}, 32'(bus.best_valid), 1);
        chk({name, "_best_sad"}, 32'(bus.best_sad), bs);
        chk({name, "_best_idx"}, 32'(bus.best_idx), bi);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit exp_v;
        if (rst) begin
            q.delete();
            hold_sad = 0;
            hold_idx = 0;
            mbs = ACC_MAX;
            mbi = 0;
            mbv = 1'b0;
            chk("rst_sad_valid", 32'(bus.sad_valid), 0);
            chk("rst_sad_out", 32'(bus.sad_out), 0);
            chk("rst_sad_idx", 32'(bus.sad_idx), 0);
            chk("rst_best_valid", 32'(bus.best_valid), 0);
            chk("rst_best_sad", 32'(bus.best_sad), ACC_MAX);
            chk("rst_best_idx", 32'(bus.best_idx), 0);
        end else begin
            exp_v = 1'b0;
            while (q.size() > 0 && q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_pulse: got none expected sad %0d due cycle %0d", q[0].sad, q[0].due);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].due == cyc) begin
                exp_v = 1'b1;
                hold_sad = q[0].sad;
                hold_idx = q[0].idx;
                void'(q.pop_front());
            end
            chk("sad_valid", 32'(bus.sad_valid), 32'(exp_v));
            chk("sad_out", 32'(bus.sad_out), hold_sad);
            chk("sad_idx", 32'(bus.sad_idx), hold_idx);
            chk("best_valid", 32'(bus.best_valid), 32'(mbv));
            chk("best_sad", 32'(bus.best_sad), mbs);
            if (mbv) chk("best_idx", 32'(bus.best_idx), mbi);
            if (exp_v && (bus.search_clear || !mbv || hold_sad < mbs)) begin
                mbs = hold_sad;
                mbi = hold_idx;
                mbv = 1'b1;
            end else if (bus.search_clear) begin
                mbs = ACC_MAX;
                mbv = 1'b0;
            end
        end
    end

    initial begin
        logic [LANES*PIX_W-1:0] a, b;
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.cand_idx = '0;
        bus.a_pix    = '0;
        bus.b_pix    = '0;
        bus.search_clear = 1'b0;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // single-row block: 16 lanes * 7 = 112
        drive(1, 1, 1, 5, fill(10), fill(3), 0);
        wait_sad("single_row", 112, 5);
        check_best("single_row", 112, 5);

        // lanes 0/1 mirrored, others equal
        a = fill(77); b = fill(77);
        a[7:0] = 8'd0;    b[7:0] = 8'd200;
        a[15:8] = 8'd200; b[15:8] = 8'd0;
        drive(1, 1, 1, 6, a, b, 0);
        wait_sad("abs_sym", 400, 6);

        // 16 rows with random gaps, then back-to-back
        for (int r = 0; r < 16; r++) begin
            drive(1, r == 0, r == 15, 7, fill(255), fill(0), 0);
            idle($urandom_range(0, 2));
        end
        wait_sad("rows16_gaps", 65280, 7);
        for (int r = 0; r < 16; r++) drive(1, r == 0, r == 15, 8, fill(255), fill(0), 0);
        wait_sad("rows16_b2b", 65280, 8);

        // minimum tracking over 300/120/120
        idle(1, 1'b1);
        a = '0; b = '0;
        a[7:0] = 8'd255; a[15:8] = 8'd45;
        drive(1, 1, 1, 1, a, b, 0);
        a = '0; a[7:0] = 8'd120;
        drive(1, 1, 1, 2, a, b, 0);
        drive(1, 1, 1, 3, a, b, 0);
        idle(8);
        check_best("min_track", 120, 2);

        // clear lands on the same cycle as the 500 SAD tracker update
        a = '0; a[7:0] = 8'd255; a[15:8] = 8'd245;
        drive(1, 1, 1, 4, a, b, 0);
        idle(5);
        idle(1, 1'b1);
        check_best("clear_collide", 500, 4);

        // 17 rows of 4080 exceed 16 bits
        for (int r = 0; r < 17; r++) drive(1, r == 0, r == 16, 10, fill(255), fill(0), 0);
        wait_sad("saturate", ACC_MAX, 10);

        // reset while a partial block is in flight; next unmarked-first row must start from 0
        for (int r = 0; r < 3; r++) drive(1, r == 0, 0, 11, fill(200), fill(0), 0);
        do_reset(2);
        drive(1, 0, 1, 9, fill(1), fill(0), 0);
        wait_sad("post_reset", 16, 9);
        check_best("post_reset", 16, 9);

        // random beats, bubbles, block boundaries and clears
        for (int n = 0; n < 500; n++) begin
            a = {$urandom, $urandom, $urandom, $urandom};
            b = {$urandom, $urandom, $urandom, $urandom};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                  int'($urandom_range(0, 255)), a, b, $urandom_range(0, 40) == 0);
        end
        idle(12);
        @(negedge clk);
        chk("drain_queue", 32'(q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
